// File: rtl/apo_traffic_gen_16.sv
// LFSR-driven synthetic packet source for the 16-node circulant NoC.
// Injects one packet per slot, round-robin over source ports, at a programmable rate.
module apo_traffic_gen_16 #(
  parameter int N2    = 11,
  parameter int NODES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    rate,
  input  logic [7:0]    count,
  input  logic [15:0]   seed,
  output logic [N2-1:0] out_router1,
  output logic [N2-1:0] out_router2,
  output logic [N2-1:0] out_router3,
  output logic [N2-1:0] out_router4,
  output logic [N2-1:0] out_router5,
  output logic [N2-1:0] out_router6,
  output logic [N2-1:0] out_router7,
  output logic [N2-1:0] out_router8,
  output logic [N2-1:0] out_router9,
  output logic [N2-1:0] out_router10,
  output logic [N2-1:0] out_router11,
  output logic [N2-1:0] out_router12,
  output logic [N2-1:0] out_router13,
  output logic [N2-1:0] out_router14,
  output logic [N2-1:0] out_router15,
  output logic [N2-1:0] out_router16,
  output logic          busy,
  output logic          done,
  output logic [15:0]   sent_cnt
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | seed the LFSR from the latched seed
  // INJECT | one packet on out_router(src+1) this cycle
  // GAP    | rate idle cycles between injections
  // DONE   | one-cycle done pulse, back to IDLE

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INJECT,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nxt;
  logic [3:0]    src;
  logic [3:0]    rate_q;
  logic [3:0]    gap_cnt;
  logic [7:0]    count_q;
  logic [15:0]   seed_q;
  logic [15:0]   sent_inc;
  logic [3:0]    dst;
  logic [N2-1:0] pkt;
  logic [N2-1:0] port [NODES];

  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
  assign sent_inc = (sent_cnt == 16'hFFFF) ? sent_cnt : sent_cnt + 16'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !stop) state_nxt = S_LOAD;
      S_LOAD: state_nxt = stop ? S_IDLE : S_INJECT;
      S_INJECT: begin
        if (stop)                                           state_nxt = S_IDLE;
        else if (count_q != 8'd0 && sent_inc == {8'd0, count_q}) state_nxt = S_DONE;
        else if (rate_q == 4'd0)                            state_nxt = S_INJECT;
        else                                                state_nxt = S_GAP;
      end
      S_GAP: begin
        if (stop)                  state_nxt = S_IDLE;
        else if (gap_cnt == 4'd1)  state_nxt = S_INJECT;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lfsr     <= LFSR_INIT;
      src      <= 4'd0;
      rate_q   <= 4'd0;
      gap_cnt  <= 4'd0;
      count_q  <= 8'd0;
      seed_q   <= 16'd0;
      sent_cnt <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_LOAD) || (state_nxt == S_INJECT) || (state_nxt == S_GAP);
      done  <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (state_nxt == S_LOAD) begin
            rate_q   <= rate;
            count_q  <= count;
            seed_q   <= seed;
            sent_cnt <= 16'd0;
            src      <= 4'd0;
          end
        end
        S_LOAD: begin
          if (!stop) lfsr <= (seed_q == 16'd0) ? LFSR_INIT : seed_q;
        end
        // A stop here still accounts for the packet already on the wire.
        S_INJECT: begin
          sent_cnt <= sent_inc;
          lfsr     <= lfsr_nxt;
          src      <= src + 4'd1;
          if (state_nxt == S_GAP) gap_cnt <= rate_q;
        end
        S_GAP:   gap_cnt <= gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Self-addressed destinations are bumped to the next node.
  assign dst = (lfsr[3:0] == src) ? src + 4'd1 : lfsr[3:0];
  assign pkt = {1'b1, dst, lfsr[9:4]};

  for (genvar i = 0; i < NODES; i++) begin : g_port
    localparam logic [3:0] IDX = 4'(i);
    assign port[i] = (state == S_INJECT && src == IDX) ? pkt : '0;
  end

  assign out_router1  = port[0];
  assign out_router2  = port[1];
  assign out_router3  = port[2];
  assign out_router4  = port[3];
  assign out_router5  = port[4];
  assign out_router6  = port[5];
  assign out_router7  = port[6];
  assign out_router8  = port[7];
  assign out_router9  = port[8];
  assign out_router10 = port[9];
  assign out_router11 = port[10];
  assign out_router12 = port[11];
  assign out_router13 = port[12];
  assign out_router14 = port[13];
  assign out_router15 = port[14];
  assign out_router16 = port[15];

endmodule

// File: doc/apo_traffic_gen_16.md
# apo_traffic_gen_16

Synthetic traffic source for the 16-node circulant (APO) NoC top level. It sits upstream of the routers and drives all sixteen `in_free` packet inputs. It replaces manual switch/key packet selection with an LFSR-driven, rate-controlled injection sequence for bring-up and load testing. One packet is injected per injection slot, round-robin over source nodes, with a pseudo-random destination and payload.

## Interface
- `N2`, default 11: packet width. Format is fixed:
  - bit 10: valid
  - bits [9:6]: destination node 0..15
  - bits [5:0]: payload
- `NODES`, default 16: number of router ports. Fixed at 16.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `start` input 1: level sampled in IDLE; launches a run.
- `stop` input 1: aborts a run from any state.
- `rate` input 4: idle cycles between consecutive injections. Latched at start.
- `count` input 8: packets per run; 0 = continuous. Latched at start.
- `seed` input 16: LFSR seed; 0 is replaced by 16'hACE1. Latched at start.
- `out_router1` .. `out_router16` output N2 each: packet to router node 0..15.
- `busy` output 1: high in LOAD, INJECT, GAP.
- `done` output 1: one-cycle pulse at normal run completion.
- `sent_cnt` output 16: packets injected in current or last run; saturates at 16'hFFFF.

## Operation
- Internal state:
  - 16-bit Galois LFSR, right shift, mask 16'hB400: next = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 0).
  - 4-bit source pointer `src`.
  - latched rate, count, gap counter, `sent_cnt`.
- Packet for the current slot: valid = 1; dst = l[3:0]; payload = l[9:4].
  - If dst == src, dst = src + 1 mod 16 (no self-addressed packets).
- Output decode: `out_router(i+1)` = packet when state == INJECT and src == i, else 0. Exactly one port is non-zero at a time.
- FSM states: IDLE, LOAD, INJECT, GAP, DONE.
  - IDLE: start=1 -> LOAD. On this edge: latch rate, count, seed; clear `sent_cnt`; src = 0.
  - LOAD: LFSR = seed (or ACE1 if seed is 0) -> INJECT.
  - INJECT, on exit:
    - `sent_cnt` += 1 (saturating);
    - LFSR advances one step;
    - src increments, wrapping 15 -> 0.
  - INJECT next state:
    - count != 0 and new `sent_cnt` == count -> DONE;
    - else rate == 0 -> INJECT (back-to-back);
    - else GAP with gap counter = rate.
  - GAP: counter decrements each cycle; on reaching 1 -> INJECT. GAP lasts exactly `rate` cycles.
  - DONE: done = 1 for one cycle -> IDLE.
- `stop` = 1 in LOAD, INJECT, GAP or DONE -> IDLE on the next edge.
  - A stop in INJECT still counts that packet.
  - No done pulse is produced.
  - `sent_cnt` is retained.
- Priority: stop over completion and over start.
- `start` is ignored outside IDLE. `start` held high re-launches immediately after DONE -> IDLE (one IDLE cycle between runs).
- Continuous mode (count = 0) runs until stop. `sent_cnt` saturates while injection continues.

## Timing
- Reset values: state IDLE, LFSR 16'hACE1, src 0, `sent_cnt` 0, busy 0, done 0, all `out_router` 0.
- Reset asserted mid-run clears everything asynchronously. The packet output drops to 0 in the same cycle.
- start sampled at edge T: LOAD during T..T+1; first packet visible during cycle T+1..T+2 (first INJECT cycle).
- Each packet is valid for exactly one clock cycle. The injection period is `rate` + 1 cycles.
- busy is registered from state. done is high during the DONE cycle, one cycle after the last INJECT.
- Outputs are decoded from registered state, src and LFSR only. There is no combinational path from inputs to `out_router`.

## Test plan
- First packet: reset; seed 0, count 1, rate 0; start pulse.
  - Required: `out_router1` = 11'h44E (dst 1, payload 0x0E) for one cycle; all other ports 0.
  - done pulses on the next cycle; `sent_cnt` = 1; busy = 0 afterwards.
- Round-robin wrap: count 20, rate 0.
  - Required: 20 consecutive cycles with one valid packet each, source sequence 0..15, 0..3.
  - No packet has dst == src; `sent_cnt` = 20.
- Gap: count 3, rate 5.
  - Required: packets exactly 6 cycles apart; busy high from LOAD through the third INJECT; done pulses once.
- Stop mid-GAP: count 0, rate 3; assert stop in the second GAP cycle after the 4th packet.
  - Required: IDLE next cycle; no further packets; done stays 0; `sent_cnt` = 4.
- Async reset mid-INJECT: assert `rst_n` low while `out_router` is non-zero.
  - Required: outputs 0 immediately; after release, state IDLE and `sent_cnt` = 0.
- Back-to-back runs: start held high, count 2.
  - Required: done, then exactly one IDLE cycle, then LOAD. The second run repeats the same packet sequence for the same seed.
